// File: rtl/bp_stream_to_lite_gather.sv
// Gathers a wrapped BedRock stream (header + narrow beat each) into one
// wide BedRock Lite message {header, data}.
module bp_stream_to_lite_gather #(
    parameter int paddr_width_p = 40,
    parameter int lce_id_width_p = 8,
    parameter int in_data_width_p = 64,
    parameter int out_data_width_p = 512,
    parameter int payload_width_p = lce_id_width_p + 8,
    parameter logic [15:0] payload_mask_p = '0,
    localparam int in_msg_header_width_lp = payload_width_p + 3 + paddr_width_p + 4,
    localparam int out_msg_width_lp = in_msg_header_width_lp + out_data_width_p
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
    input  logic [in_data_width_p-1:0]        in_msg_data_i,
    input  logic                              in_msg_v_i,
    output logic                              in_msg_ready_and_o,
    input  logic                              in_msg_lock_i,
    output logic [out_msg_width_lp-1:0]       out_msg_o,
    output logic                              out_msg_v_o,
    input  logic                              out_msg_ready_and_i
);

    localparam int beat_bytes_lp = in_data_width_p / 8;
    localparam int max_beats_lp = out_data_width_p / in_data_width_p;
    localparam int off_w_lp = $clog2(beat_bytes_lp);
    localparam int ptr_w_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;

    if (in_data_width_p > out_data_width_p
        || (out_data_width_p % in_data_width_p) != 0) begin : g_bad_width
        $error("bp_stream_to_lite_gather: illegal data width ratio");
    end

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        logic [3:0]                 msg_type;
    } hdr_t;

    typedef enum logic [1:0] {
        e_ready,
        e_gather,
        e_full
    } state_e;

    typedef logic [max_beats_lp-1:0][in_data_width_p-1:0] buf_t;

    state_e              state_q, state_d;
    logic [ptr_w_lp-1:0] beats_left_q, beats_left_d;
    hdr_t                hdr_q, hdr_d;
    buf_t                data_q, data_d;

    hdr_t                in_hdr;
    logic [ptr_w_lp-1:0] slot;
    logic                has_data;
    int                  shamt;
    int                  beats_n;
    logic [ptr_w_lp-1:0] beats_m1;
    logic                in_hs;

    assign in_hdr = in_msg_header_i;
    assign slot = in_hdr.addr[off_w_lp +: ptr_w_lp];
    assign in_hs = in_msg_v_i & in_msg_ready_and_o;

    // Beat count is derived from the first beat's header only
    always_comb begin
        has_data = payload_mask_p[in_hdr.msg_type];
        shamt = (int'(in_hdr.size) > off_w_lp) ? int'(in_hdr.size) - off_w_lp : 0;
        beats_n = has_data ? (1 << shamt) : 1;
        if (beats_n > max_beats_lp) begin
            beats_n = max_beats_lp;
        end
        beats_m1 = ptr_w_lp'(beats_n - 1);
    end

    always_comb begin
        state_d = state_q;
        beats_left_d = beats_left_q;
        hdr_d = hdr_q;
        data_d = data_q;
        in_msg_ready_and_o = 1'b0;
        out_msg_v_o = 1'b0;
        unique case (state_q)
            e_ready: begin
                in_msg_ready_and_o = 1'b1;
                if (in_msg_v_i) begin
                    hdr_d = in_hdr;
                    beats_left_d = beats_m1;
                    if (beats_m1 == '0) begin
                        data_d = {max_beats_lp{in_msg_data_i}};
                        state_d = e_full;
                    end else begin
                        data_d[slot] = in_msg_data_i;
                        state_d = e_gather;
                    end
                end
            end
            e_gather: begin
                in_msg_ready_and_o = 1'b1;
                if (in_msg_v_i) begin
                    data_d[slot] = in_msg_data_i;
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_d == '0) begin
                        state_d = e_full;
                    end
                end
            end
            e_full: begin
                out_msg_v_o = 1'b1;
                if (out_msg_ready_and_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            beats_left_q <= '0;
            hdr_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            beats_left_q <= beats_left_d;
            hdr_q <= hdr_d;
            data_q <= data_d;
        end
    end

    assign out_msg_o = {hdr_q, data_q};

    // Lock must drop exactly on the final beat of a message
    a_lock: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        in_hs |-> (in_msg_lock_i == (beats_left_d != '0)))
        else $error("bp_stream_to_lite_gather: lock mismatch");

    a_hdr: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (in_hs && state_q == e_gather) |->
            (in_hdr.msg_type == hdr_q.msg_type
             && in_hdr.size == hdr_q.size
             && in_hdr.addr[paddr_width_p-1:off_w_lp+ptr_w_lp]
                == hdr_q.addr[paddr_width_p-1:off_w_lp+ptr_w_lp]))
        else $error("bp_stream_to_lite_gather: header drift within message");

endmodule

// File: tb/tb_bp_stream_to_lite_gather.sv
// Scoreboard bench for bp_stream_to_lite_gather: directed cases, reset
// mid-gather and a randomized mixed-message run.
module tb_bp_stream_to_lite_gather;

    localparam int HW = 63;
    localparam int DW = 512;
    localparam int OW = HW + DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [HW-1:0] in_hdr;
    logic [63:0]   in_data;
    logic          in_v;
    logic          in_ready;
    logic          in_lock;
    logic [OW-1:0] out_msg;
    logic          out_v;
    logic          out_ready;

    always #5 clk = ~clk;

    bp_stream_to_lite_gather #(
        .payload_mask_p(16'h0002)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .in_msg_header_i(in_hdr),
        .in_msg_data_i(in_data),
        .in_msg_v_i(in_v),
        .in_msg_ready_and_o(in_ready),
        .in_msg_lock_i(in_lock),
        .out_msg_o(out_msg),
        .out_msg_v_o(out_v),
        .out_msg_ready_and_i(out_ready)
    );

    int            n_checks = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            first_acc = 0;
    int            last_acc = 0;
    int            hs_q[$];
    logic [OW-1:0] sb_q[$];
    logic [OW-1:0] last_out;
    logic [63:0]   model_buf[8];

    task automatic check(input string tag, input logic [639:0] got,
                         input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(logic [15:0] pl, logic [2:0] sz,
                                             logic [39:0] a, logic [3:0] mt);
        return {pl, sz, a, mt};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 80000) begin
            $display("FAIL watchdog: cycles %0d limit %0d", cyc, 80000);
            $fatal(1);
        end
    end

    // Consumer: choose ready, and compare whenever a handshake is set up
    always @(negedge clk) begin
        logic [OW-1:0] exp;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom % 2);
            default: out_ready = 1'b0;
        endcase
        if (reset_n && out_v && out_ready) begin
            hs_q.push_back(cyc);
            last_out = out_msg;
            if (sb_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp = sb_q.pop_front();
                check("out_hdr", out_msg[OW-1:DW], exp[OW-1:DW]);
                check("out_data", out_msg[DW-1:0], exp[DW-1:0]);
            end
        end
    end

    task automatic send_msg(input logic [3:0] mt, input logic [2:0] sz,
                            input logic [39:0] addr, input logic [15:0] pl,
                            input logic [63:0] base, input bit fixed,
                            input int gap_max, input bit push,
                            input int stop_after);
        int            beats;
        int            to;
        int            g;
        logic [63:0]   d[8];
        logic [39:0]   ba[8];
        logic [39:0]   mask;
        logic [DW-1:0] ed;
        beats = 1;
        if (mt == 4'd1 && sz > 3) beats = (1 << sz) / 8;
        mask = 40'((1 << sz) - 1);
        for (int i = 0; i < beats; i++) begin
            d[i] = fixed ? base + 64'(i) : {$urandom, $urandom};
            ba[i] = (addr & ~mask) | ((addr + 40'(i * 8)) & mask);
        end
        if (push) begin
            if (beats == 1) begin
                for (int w = 0; w < 8; w++) model_buf[w] = d[0];
            end else begin
                for (int i = 0; i < beats; i++) model_buf[ba[i][5:3]] = d[i];
            end
            for (int w = 0; w < 8; w++) ed[w*64 +: 64] = model_buf[w];
            sb_q.push_back({mk_hdr(pl, sz, addr, mt), ed});
        end
        for (int i = 0; i < beats; i++) begin
            if (stop_after != 0 && i == stop_after) break;
            g = $urandom_range(gap_max, 0);
            in_v = 1'b0;
            repeat (g) @(negedge clk);
            in_hdr = mk_hdr(pl, sz, ba[i], mt);
            in_data = d[i];
            in_lock = (i != beats - 1);
            in_v = 1'b1;
            to = 0;
            while (1) begin
                #1;
                if (in_ready) break;
                @(negedge clk);
                to++;
                if (to > 500) begin
                    check("in_timeout", 0, 1);
                    break;
                end
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(negedge clk);
        end
        in_v = 1'b0;
        in_lock = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        in_v = 1'b0;
        in_lock = 1'b0;
        in_hdr = '0;
        in_data = '0;
        out_ready = 1'b0;
        for (int w = 0; w < 8; w++) model_buf[w] = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_out_v", out_v, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_msg", out_msg, 0);
        @(negedge clk);

        // 1: aligned 64B, 8 beats
        rdy_mode = 0;
        hs_q.delete();
        send_msg(4'd1, 3'd6, 40'h80_0000_0000, 16'h0101, 64'h1000, 1, 0, 1, 0);
        drain();
        check("t1_latency", hs_q[0] - first_acc, 8);
        check("t1_hdr_addr", last_out[DW+4 +: 40], 40'h80_0000_0000);
        check("t1_word3", last_out[3*64 +: 64], 64'h1003);

        // 2: critical-word-first wrap
        send_msg(4'd1, 3'd6, 40'h80_0000_0028, 16'h0202, 64'hA0, 1, 0, 1, 0);
        drain();
        check("t2_word5", last_out[5*64 +: 64], 64'hA0);
        check("t2_word4", last_out[4*64 +: 64], 64'hA7);
        check("t2_hdr_addr", last_out[DW+4 +: 40], 40'h80_0000_0028);

        // 3: non-data type, single beat replicated
        hs_q.delete();
        send_msg(4'd2, 3'd6, 40'h80_0000_0040, 16'h0303, 64'hDEAD_BEEF, 1, 0, 1, 0);
        drain();
        check("t3_latency", hs_q[0] - first_acc, 1);
        check("t3_word7", last_out[7*64 +: 64], 64'hDEAD_BEEF);

        // 4: 8B message held by back-pressure, second message waits
        rdy_mode = 2;
        hs_q.delete();
        send_msg(4'd1, 3'd3, 40'h80_0000_0100, 16'h0404,
                 64'h1122_3344_5566_7788, 1, 0, 1, 0);
        fork
            send_msg(4'd1, 3'd3, 40'h80_0000_0108, 16'h0405,
                     64'h0BAD_F00D, 1, 0, 1, 0);
            begin
                for (int k = 0; k < 5; k++) begin
                    #2;
                    check("t4_in_ready_low", in_ready, 0);
                    check("t4_out_v_held", out_v, 1);
                    check("t4_out_stable", out_msg, sb_q[0]);
                    if (k == 4) rdy_mode = 0;
                    @(negedge clk);
                end
            end
        join
        drain();
        check("t4_next_accept", first_acc - hs_q[0], 1);
        check("t4_word6", last_out[6*64 +: 64], 64'h0BAD_F00D);

        // 6: reset after beat 3 of 8
        send_msg(4'd1, 3'd6, 40'h80_0000_0218, 16'h0606, 64'h5000, 1, 0, 0, 3);
        reset_n = 1'b0;
        #1;
        check("t6_out_v_rst", out_v, 0);
        repeat (2) @(negedge clk);
        check("t6_out_v_hold", out_v, 0);
        reset_n = 1'b1;
        for (int w = 0; w < 8; w++) model_buf[w] = '0;
        @(negedge clk);
        check("t6_out_v_after", out_v, 0);
        send_msg(4'd1, 3'd6, 40'h80_0000_0200, 16'h0607, 64'h6000, 1, 0, 1, 0);
        drain();
        check("t6_word0", last_out[63:0], 64'h6000);

        // 5: random mixed traffic with gaps both sides
        rdy_mode = 1;
        for (int m = 0; m < 1000; m++) begin
            logic [3:0]  mt;
            logic [39:0] a;
            int          r;
            r = $urandom % 4;
            mt = (r < 2) ? 4'd1 : ((r == 2) ? 4'd2 : 4'd0);
            a = 40'h80_0000_0000 + 40'({$urandom_range(1023, 0), 6'b0})
                + 40'({$urandom_range(7, 0), 3'b0});
            send_msg(mt, 3'($urandom_range(6, 0)), a, 16'($urandom), 64'h0, 0, 2, 1, 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
